// File: rtl/artyz7_led_driver_systemverilog_if.sv
// Configuration port for the Arty Z7 LED PWM driver.
//
// Purpose: carries one duty-cycle update per valid/ready handshake from the
// control side (master) to the LED driver (slave).
//
// Signals:
//   cfg_valid      master -> slave  request valid; hold it and its data until cfg_ready=1
//   cfg_ready      slave -> master  driver can accept a request
//   cfg_led_index  master -> slave  target LED (IDX_W bits)
//   cfg_duty       master -> slave  on-time in ticks per PWM period
//   cfg_blink      master -> slave  blink enable (only with ARTYZ7_LED_BLINK_EN defined)
//
// Build option: ARTYZ7_LED_BLINK_EN adds the cfg_blink signal.

interface artyz7_led_driver_systemverilog_if #(
    parameter int IDX_W    = 2,
    parameter int PWM_BITS = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [IDX_W-1:0]    cfg_led_index;
    logic [PWM_BITS-1:0] cfg_duty;
`ifdef ARTYZ7_LED_BLINK_EN
    logic                cfg_blink;

    modport master (
        output cfg_valid,
        output cfg_led_index,
        output cfg_duty,
        output cfg_blink,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_led_index,
        input  cfg_duty,
        input  cfg_blink,
        output cfg_ready
    );
`else
    modport master (
        output cfg_valid,
        output cfg_led_index,
        output cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_led_index,
        input  cfg_duty,
        output cfg_ready
    );
`endif
endinterface

// File: rtl/artyz7_led_driver_systemverilog.sv
// Arty Z7 user-LED PWM driver.
//
// Purpose: drives led[0:NUM_LEDS-1] with per-LED PWM brightness. Duty values
// arrive over a valid/ready config port, wait in a shadow register and are
// committed only on a PWM period boundary so an LED never sees a partial period.
//
// Ports:
//   ext_clk    in   single clock, rising edge
//   ext_rst_n  in   asynchronous active-low reset
//   cfg        slave modport of artyz7_led_driver_systemverilog_if
//   led        out  [0:NUM_LEDS-1] registered LED drive, 1 = lit
//
// Parameters: NUM_LEDS (>=1), PWM_BITS (period = 2**PWM_BITS-1 ticks),
// PRESCALE (ext_clk cycles per PWM tick, >=1), IDX_W (index width, defaults
// to $clog2(NUM_LEDS) with a minimum of 1; may be widened to match a wider bus).
//
// Build option: ARTYZ7_LED_BLINK_EN adds a per-LED blink flag committed with
// the duty; a 4-bit counter stepped on each period boundary supplies the
// blink phase (its MSB), and a blinking LED is dark while the phase is 1.
//
// Config FSM states:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | cfg_ready=1, waiting for a handshake
//   ST_PENDING | cfg_ready=0, shadow duty waits for the next period boundary

module artyz7_led_driver_systemverilog #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 125,
    parameter int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                                  ext_clk,
    input  logic                                  ext_rst_n,
    artyz7_led_driver_systemverilog_if.slave      cfg,
    output logic [0:NUM_LEDS-1]                   led
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    state_t              state;
    logic                ready_q;
    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] shadow_duty;
    logic [IDX_W-1:0]    target;
    logic [PWM_BITS-1:0] active_duty [NUM_LEDS];
    logic                tick;
    logic                boundary;
    logic                idx_ok;

`ifdef ARTYZ7_LED_BLINK_EN
    localparam int BLINK_BITS = 4;
    logic                  shadow_blink;
    logic [0:NUM_LEDS-1]   blink;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink_phase;

    assign blink_phase = blink_cnt[BLINK_BITS-1];
`endif

    assign tick     = (presc == PS_LAST);
    assign boundary = tick && (pwm_cnt == PWM_LAST);
    assign idx_ok   = int'(cfg.cfg_led_index) < NUM_LEDS;
    assign cfg.cfg_ready = ready_q;

    // Prescaler and PWM counter; pwm_cnt never reaches the all-ones value,
    // which is what lets duty = all-ones mean "always on".
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            if (tick) begin
                presc <= '0;
                if (pwm_cnt == PWM_LAST) begin
                    pwm_cnt <= '0;
                end else begin
                    pwm_cnt <= pwm_cnt + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

`ifdef ARTYZ7_LED_BLINK_EN
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            blink_cnt <= '0;
        end else if (boundary) begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`endif

    // Config FSM. A handshake that lands on a boundary cycle only moves to
    // PENDING, so its commit waits for the following boundary.
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b1;
            shadow_duty <= '0;
            target      <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                active_duty[i] <= '0;
            end
`ifdef ARTYZ7_LED_BLINK_EN
            shadow_blink <= 1'b0;
            blink        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (cfg.cfg_valid && ready_q && idx_ok) begin
                        shadow_duty <= cfg.cfg_duty;
                        target      <= cfg.cfg_led_index;
`ifdef ARTYZ7_LED_BLINK_EN
                        shadow_blink <= cfg.cfg_blink;
`endif
                        ready_q     <= 1'b0;
                        state       <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    ready_q <= 1'b0;
                    if (boundary) begin
                        // Decode by compare so an index register wider than
                        // the LED count never addresses past the array.
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (target == IDX_W'(i)) begin
                                active_duty[i] <= shadow_duty;
`ifdef ARTYZ7_LED_BLINK_EN
                                blink[i] <= shadow_blink;
`endif
                            end
                        end
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            led <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef ARTYZ7_LED_BLINK_EN
                led[i] <= (active_duty[i] > pwm_cnt) && !(blink[i] && blink_phase);
`else
                led[i] <= (active_duty[i] > pwm_cnt);
`endif
            end
        end
    end

endmodule

// File: tb/tb_artyz7_led_driver_systemverilog.sv
// Directed bench for artyz7_led_driver_systemverilog with PRESCALE=2 and
// PWM_BITS=4: one PWM period is 15 ticks = 30 clocks, and boundaries fall on
// clock edges 30, 60, 90, ... counted from reset release. The index bus is
// 3 bits wide so an out-of-range index (5) can be presented to 4 LEDs.

module tb_artyz7_led_driver_systemverilog;

    localparam int NUM_LEDS = 4;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;
    localparam int IDX_W    = 3;

    logic                ext_clk = 1'b0;
    logic                ext_rst_n = 1'b0;
    logic [0:NUM_LEDS-1] led;

    artyz7_led_driver_systemverilog_if #(.IDX_W(IDX_W), .PWM_BITS(PWM_BITS)) cfg_if ();

    artyz7_led_driver_systemverilog #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE),
        .IDX_W    (IDX_W)
    ) dut (
        .ext_clk   (ext_clk),
        .ext_rst_n (ext_rst_n),
        .cfg       (cfg_if),
        .led       (led)
    );

    always #5 ext_clk = ~ext_clk;

    // Clock edges since reset release; boundary edges are multiples of 30.
    int cyc = 0;
    always @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) cyc = 0;
        else            cyc = cyc + 1;
    end

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int cnt_led [NUM_LEDS];
    int cnt_rdy;
    int cnt_nz;
    logic [0:NUM_LEDS-1] first_led;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic drive(input int idx, input int duty, input logic blink);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_led_index = IDX_W'(idx);
        cfg_if.cfg_duty      = PWM_BITS'(duty);
`ifdef ARTYZ7_LED_BLINK_EN
        cfg_if.cfg_blink     = blink;
`else
        if (blink) cfg_if.cfg_valid = 1'b1;
`endif
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < NUM_LEDS; i++) cnt_led[i] = 0;
        cnt_rdy = 0;
        cnt_nz  = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (k == 0) first_led = led;
            for (int i = 0; i < NUM_LEDS; i++) cnt_led[i] += int'(led[i]);
            cnt_rdy += int'(cfg_if.cfg_ready);
            if (led != '0) cnt_nz++;
        end
    endtask

    // Bounded wait for the commit; the commit edge must be a boundary edge.
    task automatic wait_commit(input string tag);
        int n = 0;
        while (cfg_if.cfg_ready !== 1'b1 && n < 70) begin
            step();
            n++;
        end
        chk({tag, "_ready_rise"}, 32'(cfg_if.cfg_ready), 1);
        chk({tag, "_commit_on_boundary"}, 32'(cyc % 30), 0);
    endtask

    initial begin
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_led_index = '0;
        cfg_if.cfg_duty      = '0;
`ifdef ARTYZ7_LED_BLINK_EN
        cfg_if.cfg_blink     = 1'b0;
`endif

        // 1. reset and idle
        repeat (3) step();
        chk("in_reset_led", 32'(led), 0);
        ext_rst_n = 1'b1;
        chk("reset_led", 32'(led), 0);
        chk("reset_ready", 32'(cfg_if.cfg_ready), 1);
        run_count(100);
        chk("idle_led_stays_zero", 32'(cnt_nz), 0);
        chk("idle_ready_held", 32'(cnt_rdy), 100);

        // 2. idx0 duty 15 -> always on
        drive(0, 15, 1'b0);
        step();
        chk("t2_ready_drop", 32'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
        wait_commit("t2");
        run_count(30);
        chk("t2_led0_always_on", 32'(cnt_led[0]), 30);
        chk("t2_led1_off", 32'(cnt_led[1]), 0);
        chk("t2_led2_off", 32'(cnt_led[2]), 0);
        chk("t2_led3_off", 32'(cnt_led[3]), 0);

        // 3. idx2 duty 5 -> 10 of 30 clocks, starting at pwm_cnt=0
        drive(2, 5, 1'b0);
        step();
        chk("t3_ready_drop", 32'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
        wait_commit("t3");
        run_count(30);
        chk("t3_led2_high_clocks", 32'(cnt_led[2]), 10);
        chk("t3_led2_first_high", 32'(first_led[2]), 1);
        chk("t3_led0_still_on", 32'(cnt_led[0]), 30);

        // 4. back-to-back idx1 duty 3 then duty 9, valid held
        drive(1, 3, 1'b0);
        step();
        chk("t4_first_accept", 32'(cfg_if.cfg_ready), 0);
        drive(1, 9, 1'b0);
        wait_commit("t4a");
        step();   // second request accepted on the edge after the commit
        chk("t4_second_accept", 32'(cfg_if.cfg_ready), 0);
        chk("t4_led1_first_clock", 32'(led[1]), 1);
        cfg_if.cfg_valid = 1'b0;
        run_count(29);
        chk("t4_led1_duty3_clocks", 32'(cnt_led[1] + 1), 6);
        chk("t4b_ready_rise", 32'(cfg_if.cfg_ready), 1);
        chk("t4b_commit_on_boundary", 32'(cyc % 30), 0);
        run_count(30);
        chk("t4_led1_duty9_clocks", 32'(cnt_led[1]), 18);
        chk("t4_led2_unchanged", 32'(cnt_led[2]), 10);

        // 5. out-of-range index is discarded
        drive(5, 15, 1'b0);
        step();
        chk("t5_ready_stays", 32'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_valid = 1'b0;
        run_count(30);
        chk("t5_ready_held", 32'(cnt_rdy), 30);
        chk("t5_led1_unchanged", 32'(cnt_led[1]), 18);
        chk("t5_led3_unchanged", 32'(cnt_led[3]), 0);
        chk("t5_led0_unchanged", 32'(cnt_led[0]), 30);

        // 6. reset pulse while PENDING drops the update
        drive(3, 15, 1'b0);
        step();
        chk("t6_pending", 32'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
        repeat (3) step();
        ext_rst_n = 1'b0;
        #1;
        chk("t6_led_async_clear", 32'(led), 0);
        chk("t6_ready_async_set", 32'(cfg_if.cfg_ready), 1);
        step();
        ext_rst_n = 1'b1;
        run_count(100);
        chk("t6_dropped_never_lit", 32'(cnt_nz), 0);
        chk("t6_ready_held", 32'(cnt_rdy), 100);

`ifdef ARTYZ7_LED_BLINK_EN
        // 7. idx3 duty 15 blink -> 8 periods on, 8 periods off
        begin
            logic [31:0] smp;
            int ones;
            int bad;
            drive(3, 15, 1'b1);
            step();
            cfg_if.cfg_valid = 1'b0;
            cfg_if.cfg_blink = 1'b0;
            wait_commit("t7");
            smp = '0;
            for (int p = 0; p < 32; p++) begin
                repeat (15) step();
                smp[p] = led[3];
                repeat (15) step();
            end
            ones = 0;
            bad  = 0;
            for (int p = 0; p < 32; p++) ones += int'(smp[p]);
            for (int p = 0; p < 24; p++) if (smp[p] == smp[p + 8]) bad++;
            chk("t7_blink_on_periods", 32'(ones), 16);
            chk("t7_blink_half_period", 32'(bad), 0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
